// File: rtl/servo_pkg.sv
// Shared types and arithmetic helpers for the servo tracker: FSM states,
// pulse-width type and the saturated proportional step used per axis.
package servo_pkg;

  localparam int unsigned PW_W    = 12;
  localparam int unsigned ERR_W   = 11;
  localparam int unsigned SAT_W   = 13;
  localparam int unsigned COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    CALC_PAN,
    CALC_TILT,
    COMMIT
  } state_e;

  typedef logic        [PW_W-1:0]  pw_t;
  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic signed [SAT_W-1:0] sat_t;

  function automatic sat_t widen(pw_t p);
    return $signed({1'b0, p});
  endfunction

  function automatic pw_t sat_pw(sat_t v, pw_t lo, pw_t hi);
    if (v < widen(lo)) return lo;
    if (v > widen(hi)) return hi;
    return v[PW_W-1:0];
  endfunction

  // Deadband, proportional shift, magnitude clamp, then optional inversion.
  function automatic err_t axis_step(logic [COORD_W-1:0] coord, err_t center,
                                     err_t deadband, int unsigned kp_shift,
                                     err_t max_step, logic inv);
    err_t err;
    err_t step;
    err  = $signed({1'b0, coord}) - center;
    step = '0;
    if (err > deadband || err < -deadband) begin
      step = err >>> kp_shift;
      if (step > max_step)       step = max_step;
      else if (step < -max_step) step = -max_step;
      if (inv)                   step = -step;
    end
    return step;
  endfunction

  function automatic pw_t apply_step(pw_t pw, err_t step, pw_t lo, pw_t hi);
    return sat_pw(widen(pw) + sat_t'(step), lo, hi);
  endfunction

endpackage

// File: rtl/servo_tracker_pwm.sv
// 50 Hz hobby-servo PWM generator: counts microsecond ticks over one period and
// loads the shadow pulse width into the active register only at the wrap.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned PW_HOME   = 1500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic us_tick_i,
  input  pw_t  shadow_pw_i,
  output logic pwm_o
);

  localparam int unsigned CNT_W = $clog2(PERIOD_US);

  logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
  pw_t              active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             wrap;

  always_comb begin
    us_cnt_d = us_cnt_q;
    active_d = active_q;
    wrap     = us_tick_i && (us_cnt_q == CNT_W'(PERIOD_US - 1));
    if (wrap) begin
      us_cnt_d = '0;
      active_d = shadow_pw_i;
    end else if (us_tick_i) begin
      us_cnt_d = us_cnt_q + CNT_W'(1);
    end
    pwm_d = (32'(us_cnt_q) < 32'(active_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt_q <= '0;
      active_q <= pw_t'(PW_HOME);
      pwm_q    <= 1'b0;
    end else begin
      us_cnt_q <= us_cnt_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_tracker.sv
// Pan/tilt servo tracker: per-frame proportional correction toward screen centre,
// driving two glitch-free PWM outputs. Optional pan scan on lost target: SERVO_SCAN_EN.
module servo_tracker
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned PW_MIN      = 500,
  parameter int unsigned PW_MAX      = 2500,
  parameter int unsigned PW_HOME     = 1500,
  parameter int unsigned CENTER_X    = 400,
  parameter int unsigned CENTER_Y    = 240,
  parameter int unsigned DEADBAND    = 8,
  parameter int unsigned KP_SHIFT    = 3,
  parameter int unsigned MAX_STEP    = 50,
  parameter int unsigned PAN_INV     = 0,
  parameter int unsigned TILT_INV    = 0,
  parameter int unsigned LOST_FRAMES = 30
`ifdef SERVO_SCAN_EN
  ,
  parameter int unsigned SCAN_STEP   = 20
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vsync_i,
  input  logic         coor_valid_i,
  input  logic [9:0]   x_coor_i,
  input  logic [9:0]   y_coor_i,
  output logic         pan_pwm_o,
  output logic         tilt_pwm_o,
  output logic [11:0]  pan_pw_o,
  output logic [11:0]  tilt_pw_o,
  output logic         locked_o
);

  localparam int unsigned DIV   = CLK_FREQ / 1_000_000;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LC_W  = $clog2(LOST_FRAMES + 1);
  localparam logic [LC_W-1:0] LOST_MAX = LC_W'(LOST_FRAMES);
  localparam pw_t P_MIN = pw_t'(PW_MIN);
  localparam pw_t P_MAX = pw_t'(PW_MAX);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               us_tick;
  logic               vsync_q, frame_evt_q;
  state_e             state_q, state_d;
  logic               settle_q, settle_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               valid_q, valid_d;
  logic [LC_W-1:0]    lost_q, lost_d;
  logic               locked_q, locked_d;
  pw_t                pan_pw_q, pan_pw_d, tilt_pw_q, tilt_pw_d;
  pw_t                pan_new_q, pan_new_d, tilt_new_q, tilt_new_d;
`ifdef SERVO_SCAN_EN
  logic               scan_dir_q, scan_dir_d;
  sat_t               scan_sum;
`endif

  always_comb begin
    us_tick   = (div_cnt_q == DIV_W'(DIV - 1));
    div_cnt_d = us_tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    x_d        = x_q;
    y_d        = y_q;
    valid_d    = valid_q;
    lost_d     = lost_q;
    locked_d   = locked_q;
    pan_new_d  = pan_new_q;
    tilt_new_d = tilt_new_q;
    pan_pw_d   = pan_pw_q;
    tilt_pw_d  = tilt_pw_q;
`ifdef SERVO_SCAN_EN
    scan_dir_d = scan_dir_q;
    scan_sum   = '0;
`endif
    unique case (state_q)
      IDLE: if (frame_evt_q) begin
        state_d  = SETTLE;
        settle_d = 1'b0;
      end
      SETTLE: if (settle_q) state_d = SAMPLE;
              else          settle_d = 1'b1;
      SAMPLE: begin
        x_d     = x_coor_i;
        y_d     = y_coor_i;
        valid_d = coor_valid_i;
        if (coor_valid_i) begin
          lost_d   = '0;
          locked_d = 1'b1;
        end else begin
          if (lost_q != LOST_MAX) lost_d = lost_q + LC_W'(1);
          locked_d = 1'b0;
        end
        state_d = CALC_PAN;
      end
      CALC_PAN: begin
        pan_new_d = pan_pw_q;
        if (valid_q) begin
          pan_new_d = apply_step(pan_pw_q,
                                 axis_step(x_q, err_t'(CENTER_X), err_t'(DEADBAND), KP_SHIFT,
                                           err_t'(MAX_STEP), PAN_INV != 0), P_MIN, P_MAX);
`ifdef SERVO_SCAN_EN
        end else if (lost_q == LOST_MAX) begin
          // Bounce: clamp at the limit and flip direction in the same frame.
          if (scan_dir_q) begin
            scan_sum = widen(pan_pw_q) + sat_t'(SCAN_STEP);
            if (scan_sum >= widen(P_MAX)) begin
              pan_new_d  = P_MAX;
              scan_dir_d = 1'b0;
            end else pan_new_d = scan_sum[PW_W-1:0];
          end else begin
            scan_sum = widen(pan_pw_q) - sat_t'(SCAN_STEP);
            if (scan_sum <= widen(P_MIN)) begin
              pan_new_d  = P_MIN;
              scan_dir_d = 1'b1;
            end else pan_new_d = scan_sum[PW_W-1:0];
          end
`endif
        end
        state_d = CALC_TILT;
      end
      CALC_TILT: begin
        tilt_new_d = tilt_pw_q;
        if (valid_q)
          tilt_new_d = apply_step(tilt_pw_q,
                                  axis_step(y_q, err_t'(CENTER_Y), err_t'(DEADBAND), KP_SHIFT,
                                            err_t'(MAX_STEP), TILT_INV != 0), P_MIN, P_MAX);
        state_d = COMMIT;
      end
      COMMIT: begin
        pan_pw_d  = pan_new_q;
        tilt_pw_d = tilt_new_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      vsync_q     <= 1'b0;
      frame_evt_q <= 1'b0;
      state_q     <= IDLE;
      settle_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      lost_q      <= '0;
      locked_q    <= 1'b0;
      pan_pw_q    <= pw_t'(PW_HOME);
      tilt_pw_q   <= pw_t'(PW_HOME);
      pan_new_q   <= pw_t'(PW_HOME);
      tilt_new_q  <= pw_t'(PW_HOME);
`ifdef SERVO_SCAN_EN
      scan_dir_q  <= 1'b1;
`endif
    end else begin
      div_cnt_q   <= div_cnt_d;
      vsync_q     <= vsync_i;
      frame_evt_q <= vsync_i & ~vsync_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
      x_q         <= x_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
      locked_q    <= locked_d;
      pan_pw_q    <= pan_pw_d;
      tilt_pw_q   <= tilt_pw_d;
      pan_new_q   <= pan_new_d;
      tilt_new_q  <= tilt_new_d;
`ifdef SERVO_SCAN_EN
      scan_dir_q  <= scan_dir_d;
`endif
    end
  end

  servo_pwm_gen #(.PERIOD_US(PERIOD_US), .PW_HOME(PW_HOME)) u_pan_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .us_tick_i   (us_tick),
    .shadow_pw_i (pan_pw_q),
    .pwm_o       (pan_pwm_o)
  );

  servo_pwm_gen #(.PERIOD_US(PERIOD_US), .PW_HOME(PW_HOME)) u_tilt_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .us_tick_i   (us_tick),
    .shadow_pw_i (tilt_pw_q),
    .pwm_o       (tilt_pwm_o)
  );

  assign pan_pw_o  = pan_pw_q;
  assign tilt_pw_o = tilt_pw_q;
  assign locked_o  = locked_q;

endmodule

// File: tb/tb_servo_tracker.sv
// Scoreboard bench for servo_tracker: shortened PWM period (2 clk/us, 2600 us)
// so pulse widths and the commit/wrap boundary can be measured in a short run.
module tb_servo_tracker;

  localparam int DIV       = 2;
  localparam int PERIOD_US = 2600;
  localparam int PER_CLK   = DIV * PERIOD_US;
  localparam int BOUND     = 3 * PER_CLK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pan_pwm, tilt_pwm, locked;
  logic [11:0] pan_pw, tilt_pw;

  servo_tracker #(.CLK_FREQ(DIV * 1_000_000), .PERIOD_US(PERIOD_US)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (vsync),
    .coor_valid_i (valid),
    .x_coor_i     (x),
    .y_coor_i     (y),
    .pan_pwm_o    (pan_pwm),
    .tilt_pwm_o   (tilt_pwm),
    .pan_pw_o     (pan_pw),
    .tilt_pw_o    (tilt_pw),
    .locked_o     (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pan;
    int tilt;
    int lck;
  } exp_t;

  exp_t frame_q[$];
  int   pulse_q[$];

  int checks = 0;
  int errors = 0;
  int m_pan = 1500, m_tilt = 1500, m_lost = 0, m_locked = 0;
  bit m_dir = 1'b1;
  int lat = -1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_axis(int pw, int coord, int center);
    int err, step, np;
    err  = coord - center;
    step = 0;
    if (err > 8 || err < -8) begin
      step = err >>> 3;
      if (step > 50)  step = 50;
      if (step < -50) step = -50;
    end
    np = pw + step;
    if (np < 500)  np = 500;
    if (np > 2500) np = 2500;
    return np;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit v, input int cx, input int cy);
    exp_t e;
    int   t0, pan_prev, np;
    if (v) begin
      m_pan = model_axis(m_pan, cx, 400);
      m_tilt = model_axis(m_tilt, cy, 240);
      m_lost = 0;
      m_locked = 1;
    end else begin
      if (m_lost < 30) m_lost++;
      m_locked = 0;
`ifdef SERVO_SCAN_EN
      if (m_lost == 30) begin
        if (m_dir) begin
          np = m_pan + 20;
          if (np >= 2500) begin np = 2500; m_dir = 1'b0; end
        end else begin
          np = m_pan - 20;
          if (np <= 500) begin np = 500; m_dir = 1'b1; end
        end
        m_pan = np;
      end
`endif
    end
    np = 0;
    e.pan = m_pan; e.tilt = m_tilt; e.lck = m_locked;
    frame_q.push_back(e);
    pan_prev = int'(pan_pw);
    t0 = cyc;
    vsync = 1'b1; valid = v; x = cx[9:0]; y = cy[9:0];
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) vsync = 1'b0;
      if (lat < 0 && int'(pan_pw) != pan_prev) lat = cyc - t0;
    end
    e = frame_q.pop_front();
    check("pan_pw", int'(pan_pw), e.pan);
    check("tilt_pw", int'(tilt_pw), e.tilt);
    check("locked", int'(locked), e.lck);
  endtask

  task automatic wait_rise(output int rc);
    int n = 0;
    while (pan_pwm !== 1'b0 && n < BOUND) begin tick(1); n++; end
    while (pan_pwm !== 1'b1 && n < BOUND) begin tick(1); n++; end
    if (n >= BOUND) check("pwm_rise_timeout", n, 0);
    rc = cyc;
  endtask

  task automatic count_high(output int w);
    w = 0;
    while (pan_pwm === 1'b1 && w < BOUND) begin w++; tick(1); end
  endtask

  initial begin
    int r1, r2, w1, w2, d;
    // Reset state
    tick(3);
    check("rst_pan_pwm", int'(pan_pwm), 0);
    check("rst_tilt_pwm", int'(tilt_pwm), 0);
    check("rst_pan_pw", int'(pan_pw), 1500);
    check("rst_tilt_pw", int'(tilt_pw), 1500);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;

    // Idle: home pulse and period
    pulse_q.push_back(1500 * DIV);
    wait_rise(r1);
    check("tilt_pwm_sync", int'(tilt_pwm), 1);
    count_high(w1);
    check("home_pulse", w1, pulse_q.pop_front());
    wait_rise(r2);
    check("period", r2 - r1, PER_CLK);

    // Deadband, including |err| == 8
    send_frame(1'b1, 404, 236);
    send_frame(1'b1, 408, 248);

    // Step +10 committed mid-pulse: current pulse old, next pulse new
    pulse_q.push_back(1500 * DIV);
    pulse_q.push_back(model_axis(m_pan, 480, 400) * DIV);
    wait_rise(r1);
    fork
      send_frame(1'b1, 480, 240);
      count_high(w1);
    join
    check("cur_pulse", w1, pulse_q.pop_front());
    wait_rise(r1);
    count_high(w1);
    check("next_pulse", w1, pulse_q.pop_front());
    check("commit_lat_seen", int'(lat >= 0), 1);

    // Just outside deadband, negative error floors
    send_frame(1'b1, 409, 231);

    // Clamped steps down to PW_MIN
    for (int i = 0; i < 26; i++) send_frame(1'b1, 0, 240);

    // Commit landing on the PWM wrap edge
    pulse_q.push_back(m_pan * DIV);
    pulse_q.push_back(model_axis(m_pan, 480, 400) * DIV);
    wait_rise(r1);
    d = r1 - 1 + PER_CLK - lat;
    while (cyc < d) tick(1);
    fork
      send_frame(1'b1, 480, 240);
      begin
        wait_rise(r2);
        count_high(w1);
        check("wrap_old_pulse", w1, pulse_q.pop_front());
        wait_rise(r2);
        count_high(w2);
        check("wrap_new_pulse", w2, pulse_q.pop_front());
      end
    join

    // Lost target
`ifdef SERVO_SCAN_EN
    for (int i = 0; i < 160; i++) send_frame(1'b0, 123, 45);
`else
    for (int i = 0; i < 35; i++) send_frame(1'b0, 123, 45);
`endif
    send_frame(1'b1, 400, 240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
